pipeline_run_ctrl: RTL and testbench

- Synthesisable run controller that sequences reset and run of the five-stage RISC-V pipeline, and decides when a run ends.
- Replaces fixed-delay bench sequencing with the following:
  - a parametrised reset hold;
  - a cycle-budget watchdog;
  - architectural halt detection (ecall retire, or a self-loop on one PC).
- Sits between the bench/SoC top and pipeline_top. Drives the core reset and observes the writeback-stage retire stream.

---
 rtl/pipeline_run_ctrl_if.sv | 40 ++++
 rtl/pipeline_run_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_run_ctrl_if
//  Brief    : Run-control bundle between the bench/SoC top and the run
//             controller: start request, writeback retire stream, and the
//             controller's core reset, run status, halt flags and counters.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipeline_run_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 32
);
  logic             start;
  logic             retire_valid;
  logic [PC_W-1:0]  retire_pc;
  logic [31:0]      retire_insn;
  logic             core_rst;
  logic             busy;
  logic             done;
  logic             halt_ecall;
  logic             halt_loop;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] retire_count;

  // Requester side: issues start and presents the retire stream
  modport master (
    output start, retire_valid, retire_pc, retire_insn,
    input  core_rst, busy, done, halt_ecall, halt_loop, timeout,
           cycle_count, retire_count
  );

  // Controller side
  modport slave (
    input  start, retire_valid, retire_pc, retire_insn,
    output core_rst, busy, done, halt_ecall, halt_loop, timeout,
           cycle_count, retire_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_run_ctrl
//  Brief    : Sequences core reset and run of the five-stage pipeline and
//             ends the run on ecall retire, a single-PC self-loop, or an
//             exhausted RUN-cycle budget. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_run_ctrl #(
  parameter int          RST_CYCLES = 2,
  parameter int          MAX_CYCLES = 75,
  parameter int          LOOP_LIMIT = 4,
  parameter logic [31:0] HALT_INSN  = 32'h0000_0073,
  parameter int          CNT_W      = 16,
  parameter int          PC_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_run_ctrl_if.slave bus
);

  // Terminal values compared against the running counters
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOOP_LAST = CNT_W'(LOOP_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] retire_count_q, retire_count_d;
  logic [CNT_W-1:0] loop_run_q, loop_run_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             halt_ecall_q, halt_ecall_d;
  logic             halt_loop_q, halt_loop_d;
  logic             timeout_q, timeout_d;
  logic             core_rst_q, core_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clear_run;
  logic             hit_e, hit_l, hit_t;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, run bookkeeping and halt detection
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    cycle_count_d  = cycle_count_q;
    retire_count_d = retire_count_q;
    loop_run_d     = loop_run_q;
    last_pc_d      = last_pc_q;
    halt_ecall_d   = halt_ecall_q;
    halt_loop_d    = halt_loop_q;
    timeout_d      = timeout_q;
    clear_run      = 1'b0;
    hit_e          = 1'b0;
    hit_l          = 1'b0;
    hit_t          = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_RESET;
          clear_run = 1'b1;
        end
      end
      S_RESET: begin
        rst_cnt_d = sat_inc(rst_cnt_q);
        if (rst_cnt_q == RST_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        if (bus.retire_valid) begin
          retire_count_d = sat_inc(retire_count_q);
          last_pc_d      = bus.retire_pc;
          loop_run_d     = (loop_run_q != '0 && bus.retire_pc == last_pc_q)
                           ? sat_inc(loop_run_q) : CNT_W'(1);
        end
        hit_e = bus.retire_valid && (bus.retire_insn == HALT_INSN);
        hit_l = bus.retire_valid && (bus.retire_pc == last_pc_q) &&
                (loop_run_q == LOOP_LAST);
        // Equivalent to cycle_count+1 == MAX_CYCLES without the overflow
        hit_t = (cycle_count_q == MAX_LAST);
        // Priority ecall > loop > timeout; only one flag is ever raised
        if (hit_e)      halt_ecall_d = 1'b1;
        else if (hit_l) halt_loop_d  = 1'b1;
        else if (hit_t) timeout_d    = 1'b1;
        if (hit_e || hit_l || hit_t) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_run) begin
      rst_cnt_d      = '0;
      cycle_count_d  = '0;
      retire_count_d = '0;
      loop_run_d     = '0;
      halt_ecall_d   = 1'b0;
      halt_loop_d    = 1'b0;
      timeout_d      = 1'b0;
    end

    // Status outputs are decoded from the next state so they align with it
    core_rst_d = (state_d != S_RUN);
    busy_d     = (state_d == S_RESET) || (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rst_cnt_q      <= '0;
      cycle_count_q  <= '0;
      retire_count_q <= '0;
      loop_run_q     <= '0;
      last_pc_q      <= '0;
      halt_ecall_q   <= 1'b0;
      halt_loop_q    <= 1'b0;
      timeout_q      <= 1'b0;
      core_rst_q     <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      cycle_count_q  <= cycle_count_d;
      retire_count_q <= retire_count_d;
      loop_run_q     <= loop_run_d;
      last_pc_q      <= last_pc_d;
      halt_ecall_q   <= halt_ecall_d;
      halt_loop_q    <= halt_loop_d;
      timeout_q      <= timeout_d;
      core_rst_q     <= core_rst_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.core_rst     = core_rst_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.halt_ecall   = halt_ecall_q;
  assign bus.halt_loop    = halt_loop_q;
  assign bus.timeout      = timeout_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.retire_count = retire_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_run_ctrl
//  Brief    : Directed bench for pipeline_run_ctrl. Each run pushes its
//             expected end-of-run result into a queue; a monitor pops and
//             compares whenever done rises.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_run_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef struct {
    string       name;
    logic [2:0]  flags;  // {halt_ecall, halt_loop, timeout}
    logic [15:0] cc;
    logic [15:0] rc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  pipeline_run_ctrl_if #(.CNT_W(16), .PC_W(32)) bus ();

  pipeline_run_ctrl #(
    .RST_CYCLES(2), .MAX_CYCLES(75), .LOOP_LIMIT(4),
    .HALT_INSN(32'h0000_0073), .CNT_W(16), .PC_W(32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn);
    bus.retire_valid = v;
    bus.retire_pc    = pc;
    bus.retire_insn  = insn;
    tick();
  endtask

  task automatic push(input string nm, input logic [2:0] f, input int cc, input int rc);
    exp_t e;
    e.name  = nm;
    e.flags = f;
    e.cc    = 16'(cc);
    e.rc    = 16'(rc);
    sb.push_back(e);
  endtask

  // Pulse start and walk through the RST_CYCLES reset window
  task automatic start_run(input string nm);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({nm, "_busy_rst"}, 32'(bus.busy), 32'd1);
    chk({nm, "_core_rst0"}, 32'(bus.core_rst), 32'd1);
    chk({nm, "_done_clr"}, 32'(bus.done), 32'd0);
    chk({nm, "_flags_clr"}, 32'({bus.halt_ecall, bus.halt_loop, bus.timeout}), 32'd0);
    chk({nm, "_cnt_clr"}, {bus.cycle_count, bus.retire_count}, 32'd0);
    tick();
    chk({nm, "_core_rst1"}, 32'(bus.core_rst), 32'd1);
    tick();
    chk({nm, "_core_rst_low"}, 32'(bus.core_rst), 32'd0);
    chk({nm, "_busy_run"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_core_rst"}, 32'(bus.core_rst), 32'd1);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_flags"}, 32'({bus.halt_ecall, bus.halt_loop, bus.timeout}), 32'd0);
    chk({nm, "_counts"}, {bus.cycle_count, bus.retire_count}, 32'd0);
  endtask

  // Monitor: compare run result against the scoreboard on each done rise
  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.done && !prev_done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected no run end");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_flags"}, 32'({bus.halt_ecall, bus.halt_loop, bus.timeout}), 32'(e.flags));
          chk({e.name, "_cycle_count"}, 32'(bus.cycle_count), 32'(e.cc));
          chk({e.name, "_retire_count"}, 32'(bus.retire_count), 32'(e.rc));
        end
      end
      prev_done = rst ? 1'b0 : bus.done;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    n_checks         = 0;
    n_errors         = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.retire_valid = 1'b0;
    bus.retire_pc    = '0;
    bus.retire_insn  = '0;
    tick();
    tick();
    chk_reset_vals("por");
    rst = 1'b0;
    tick();
    tick();
    chk_reset_vals("idle");

    // Run 1: no retires, budget expiry; a start pulse mid-RUN is ignored
    push("timeout_run", 3'b001, 75, 0);
    start_run("r1");
    for (int i = 0; i < 74; i++) begin
      bus.start = (i == 10);
      tick();
    end
    bus.start = 1'b0;
    chk("r1_done_before_75", 32'(bus.done), 32'd0);
    chk("r1_cc_74", 32'(bus.cycle_count), 32'd74);
    tick();
    chk("r1_done_after_75", 32'(bus.done), 32'd1);
    chk("r1_core_rst_done", 32'(bus.core_rst), 32'd1);
    tick();
    chk("r1_cc_hold", 32'(bus.cycle_count), 32'd75);

    // Run 2: restart from DONE, ecall at 0xC after 0,4,8
    push("ecall_run", 3'b100, 5, 4);
    start_run("r2");
    step(1'b1, 32'h0, NOP);
    step(1'b1, 32'h4, NOP);
    step(1'b0, 32'h4, NOP);
    step(1'b1, 32'h8, NOP);
    step(1'b1, 32'hC, ECALL);
    bus.retire_valid = 1'b0;
    chk("r2_done_next", 32'(bus.done), 32'd1);

    // Run 3: streak broken by 0x14, then four 0x10 retires with gaps
    push("loop_run", 3'b010, 10, 7);
    start_run("r3");
    step(1'b1, 32'h10, NOP);
    step(1'b1, 32'h10, NOP);
    step(1'b1, 32'h14, NOP);
    step(1'b1, 32'h10, NOP);
    step(1'b0, 32'h10, NOP);
    step(1'b1, 32'h10, NOP);
    step(1'b0, 32'h10, NOP);
    step(1'b0, 32'h10, NOP);
    chk("r3_not_done_3rd", 32'(bus.done), 32'd0);
    step(1'b1, 32'h10, NOP);
    chk("r3_not_done_3rd_b", 32'(bus.done), 32'd0);
    step(1'b1, 32'h10, NOP);
    bus.retire_valid = 1'b0;
    chk("r3_done_4th", 32'(bus.done), 32'd1);

    // Run 4: ecall on the 4th same-PC retire wins over loop
    push("ecall_vs_loop", 3'b100, 4, 4);
    start_run("r4");
    step(1'b1, 32'h20, NOP);
    step(1'b1, 32'h20, NOP);
    step(1'b1, 32'h20, NOP);
    step(1'b1, 32'h20, ECALL);
    bus.retire_valid = 1'b0;

    // Run 5: ecall on the 75th RUN cycle wins over timeout
    push("ecall_vs_timeout", 3'b100, 75, 1);
    start_run("r5");
    for (int i = 0; i < 74; i++) step(1'b0, 32'h40, NOP);
    step(1'b1, 32'h40, ECALL);
    bus.retire_valid = 1'b0;
    chk("r5_done", 32'(bus.done), 32'd1);

    // Run 6: asynchronous reset mid-RUN, no restart without start
    start_run("r6");
    step(1'b1, 32'h50, NOP);
    step(1'b1, 32'h54, NOP);
    bus.retire_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrun_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_reset_vals("after_rst_idle");

    tick();
    tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
